vol_flag_poller: RTL and testbench
==================================

VOL_FLAG_POLLER -- requirements
Module: vol_flag_poller

Interface
REQ-001 Parameter POLL_PERIOD, default 50000, SHALL set the clock cycles between poll starts (1 ms at 50 MHz); legal range 4..2^24-1.
REQ-002 Parameter FLAG_ADDR, default 2'd0, SHALL set the word address read on the flag PIO slave.
REQ-003 Parameter DEBOUNCE, default 2, SHALL set the number of consecutive equal samples needed to change flag_level; legal range 1..15.
REQ-004 clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 enable  input  1  SHALL allow periodic polling when high.
REQ-007 poll_now  input  1  SHALL be a single-cycle request for an immediate poll.
REQ-008 avm_address  output  2  SHALL be the Avalon-MM read address.
REQ-009 avm_read  output  1  SHALL be the Avalon-MM read strobe.
REQ-010 avm_waitrequest  input  1  SHALL be the slave stall.
REQ-011 avm_readdata  input  32  SHALL be the slave read data; only bit 0 is used.
REQ-012 flag_level  output  1  SHALL be the debounced flag value.
REQ-013 flag_rise / flag_fall  output  1 each  SHALL be one-cycle pulses on a debounced 0->1 / 1->0 change.
REQ-014 rise_count  output  16  SHALL count debounced rising edges.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT_DATA and UPDATE.
REQ-016 In IDLE, a down-counter SHALL decrement while enable=1; at 0 it SHALL reload POLL_PERIOD-1 and move to REQ.
REQ-017 In IDLE, poll_now=1 SHALL move the FSM to REQ on the next edge and reload the counter, regardless of enable.
REQ-018 While enable=0, the counter SHALL hold at POLL_PERIOD-1.
REQ-019 In REQ, avm_read SHALL be 1 and avm_address SHALL be FLAG_ADDR; both SHALL hold until a cycle with avm_waitrequest=0, after which the FSM moves to WAIT_DATA.
REQ-020 avm_read SHALL be 0 in every state except REQ.
REQ-021 Read latency SHALL be fixed at 1: in WAIT_DATA, avm_readdata[0] SHALL be captured as the sample and the FSM SHALL move to UPDATE.
REQ-022 In UPDATE, a sample equal to the candidate SHALL increment a stable count (saturating at DEBOUNCE); a differing sample SHALL become the new candidate with stable count 1.
REQ-023 When the stable count reaches DEBOUNCE and the candidate differs from flag_level, flag_level SHALL update in that cycle, and flag_rise or flag_fall SHALL pulse for exactly that one cycle.
REQ-024 rise_count SHALL increment with each flag_rise and saturate at 16'hFFFF.
REQ-025 UPDATE SHALL return to IDLE unconditionally.
REQ-026 poll_now asserted outside IDLE SHALL be ignored and not queued.
REQ-027 Deasserting enable mid-transaction SHALL NOT abort it; the FSM SHALL complete through UPDATE.
REQ-028 Unbounded waitrequest SHALL keep the FSM in REQ; no timeout is required.
REQ-029 Minimum poll-to-poll spacing SHALL be POLL_PERIOD cycles when enable=1 and poll_now=0.

Reset
REQ-030 With reset=1 at a clock edge, the FSM SHALL go to IDLE and the counter SHALL load POLL_PERIOD-1.
REQ-031 Reset SHALL clear avm_read, avm_address, flag_level, flag_rise, flag_fall, rise_count, the candidate and the stable count to 0.
REQ-032 Reset during REQ SHALL deassert avm_read on that edge, and any read data arriving afterwards SHALL be ignored.

Structure
REQ-033 Package vol_flag_pkg SHALL hold the state enumeration, the 24-bit counter width and the 16-bit rise_count width.
REQ-034 The period down-counter SHALL be sub-module poll_timer, with ports clk, reset, enable, restart, expire.

Verification
REQ-035 POLL_PERIOD=10, enable=1, waitrequest=0 -> avm_read pulses for 1 cycle, with starts exactly 10 cycles apart.
REQ-036 waitrequest held high for 5 cycles in REQ -> avm_read and avm_address stay stable for 6 cycles, then the sample is captured one cycle later.
REQ-037 DEBOUNCE=2, readdata[0] sequence 0,1,0,1,1 -> a single flag_rise on the 5th UPDATE, after which rise_count=1 and flag_level=1.
REQ-038 enable=0, poll_now pulsed -> exactly one read occurs, then no further reads for 3*POLL_PERIOD cycles.
REQ-039 Reset asserted during REQ with waitrequest=1 -> next cycle avm_read=0, FSM=IDLE, all outputs 0.
REQ-040 Forced rise_count=16'hFFFE followed by 3 rising edges -> rise_count=16'hFFFF, with 3 flag_rise pulses.

Source files
------------

// File: rtl/vol_flag_pkg.sv
// Shared types and widths for the flag poller and its period timer.
package vol_flag_pkg;

   localparam int unsigned CntWidth     = 24;
   localparam int unsigned RiseCntWidth = 16;
   localparam int unsigned StableWidth  = 4;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWaitData,
      StUpdate
   } poll_state_e;

   function automatic logic [StableWidth-1:0] sat_inc(input logic [StableWidth-1:0] value,
                                                      input logic [StableWidth-1:0] limit);
      return (value >= limit) ? limit : value + 1'b1;
   endfunction

endpackage

// File: rtl/poll_timer.sv
// Poll period down-counter; parks at zero until restarted so a stalled read never loses a poll.
module poll_timer
   import vol_flag_pkg::*;
#(
   parameter int unsigned POLL_PERIOD = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   output logic expire
);

   localparam logic [CntWidth-1:0] Reload = CntWidth'(POLL_PERIOD - 1);

   logic [CntWidth-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (restart || !enable) begin
         cnt_d = Reload;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= Reload;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = enable && (cnt_q == '0);

endmodule

// File: rtl/vol_flag_poller.sv
// Periodic Avalon-MM poller for a single PIO flag bit, with debounce and edge reporting.
module vol_flag_poller
   import vol_flag_pkg::*;
#(
   parameter int unsigned POLL_PERIOD = 50000,
   parameter logic [1:0]  FLAG_ADDR   = 2'd0,
   parameter int unsigned DEBOUNCE    = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    poll_now,
   output logic [1:0]              avm_address,
   output logic                    avm_read,
   input  logic                    avm_waitrequest,
   input  logic [31:0]             avm_readdata,
   output logic                    flag_level,
   output logic                    flag_rise,
   output logic                    flag_fall,
   output logic [RiseCntWidth-1:0] rise_count
);

   localparam logic [StableWidth-1:0] DebMax = StableWidth'(DEBOUNCE);

   poll_state_e state_q, state_d;

   logic                    expire;
   logic                    restart;
   logic                    sample_q, sample_d;
   logic                    cand_q, cand_d;
   logic [StableWidth-1:0]  stable_q, stable_d;
   logic                    level_q, level_d;
   logic                    rise_q, rise_d;
   logic                    fall_q, fall_d;
   logic [RiseCntWidth-1:0] rise_count_q, rise_count_d;
   logic                    unused_readdata;

   assign unused_readdata = ^avm_readdata[31:1];

   // poll_now outside IDLE is dropped, not queued.
   assign restart = (state_q == StIdle) && (poll_now || expire);

   poll_timer #(
      .POLL_PERIOD(POLL_PERIOD)
   ) u_poll_timer (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .restart(restart),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (restart) state_d = StReq;
         StReq:      if (!avm_waitrequest) state_d = StWaitData;
         StWaitData: state_d = StUpdate;
         StUpdate:   state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_comb begin
      avm_read    = (state_q == StReq);
      avm_address = (state_q == StReq) ? FLAG_ADDR : 2'd0;
   end

   always_comb begin
      sample_d     = sample_q;
      cand_d       = cand_q;
      stable_d     = stable_q;
      level_d      = level_q;
      rise_d       = 1'b0;
      fall_d       = 1'b0;
      rise_count_d = rise_count_q;
      if (state_q == StWaitData) begin
         sample_d = avm_readdata[0];
      end
      if (state_q == StUpdate) begin
         if (sample_q == cand_q) begin
            stable_d = sat_inc(stable_q, DebMax);
         end else begin
            cand_d   = sample_q;
            stable_d = 1;
         end
         if ((stable_d == DebMax) && (cand_d != level_q)) begin
            level_d = cand_d;
            rise_d  = cand_d;
            fall_d  = !cand_d;
            if (cand_d && (rise_count_q != '1)) begin
               rise_count_d = rise_count_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sample_q     <= 1'b0;
         cand_q       <= 1'b0;
         stable_q     <= '0;
         level_q      <= 1'b0;
         rise_q       <= 1'b0;
         fall_q       <= 1'b0;
         rise_count_q <= '0;
      end else begin
         sample_q     <= sample_d;
         cand_q       <= cand_d;
         stable_q     <= stable_d;
         level_q      <= level_d;
         rise_q       <= rise_d;
         fall_q       <= fall_d;
         rise_count_q <= rise_count_d;
      end
   end

   assign flag_level = level_q;
   assign flag_rise  = rise_q;
   assign flag_fall  = fall_q;
   assign rise_count = rise_count_q;

endmodule

// File: tb/tb_vol_flag_poller.sv
// Randomised bench for vol_flag_poller: Avalon slave model plus a history-based debounce model.
module tb_vol_flag_poller;
   import vol_flag_pkg::*;

   localparam int         P    = 10;
   localparam int         DEB  = 2;
   localparam logic [1:0] ADDR = 2'd2;

   logic        clk = 1'b0;
   logic        reset, enable, poll_now;
   logic [1:0]  avm_address;
   logic        avm_read, avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        flag_level, flag_rise, flag_fall;
   logic [15:0] rise_count;

   initial forever #5 clk = ~clk;

   vol_flag_poller #(
      .POLL_PERIOD(P),
      .FLAG_ADDR  (ADDR),
      .DEBOUNCE   (DEB)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .poll_now       (poll_now),
      .avm_address    (avm_address),
      .avm_read       (avm_read),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdata   (avm_readdata),
      .flag_level     (flag_level),
      .flag_rise      (flag_rise),
      .flag_fall      (flag_fall),
      .rise_count     (rise_count)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave state
   int stall_cfg  = 0;
   int stall_left = 0;
   bit in_read    = 0;
   bit pending    = 0;
   bit cur_bit    = 0;
   bit manual_rd  = 0;
   bit samp_q[$];
   int supply_cnt = 0;

   // Reference model: level follows the last DEB samples when they all agree
   bit          hist[$];
   bit          m_level = 0;
   logic [15:0] m_rise_count = 16'd0;
   bit          m_rise_now = 0;
   bit          m_fall_now = 0;

   // Monitor state
   bit prev_read = 0;
   int run_len = 0, last_run = 0, read_cyc = 0, addr_bad = 0, rise_seen = 0, fall_seen = 0;
   int starts[$];

   function automatic void model_reset();
      hist.delete();
      m_level      = 0;
      m_rise_count = 16'd0;
      m_rise_now   = 0;
      m_fall_now   = 0;
   endfunction

   function automatic void model_update(input bit b);
      int n;
      bit all_eq;
      hist.push_back(b);
      m_rise_now = 0;
      m_fall_now = 0;
      n = hist.size();
      if (n >= DEB) begin
         all_eq = 1;
         for (int i = n - DEB; i < n; i++) if (hist[i] != b) all_eq = 0;
         if (all_eq && (b != m_level)) begin
            m_level = b;
            if (b) begin
               m_rise_now = 1;
               if (m_rise_count != 16'hFFFF) m_rise_count = m_rise_count + 16'd1;
            end else begin
               m_fall_now = 1;
            end
         end
      end
   endfunction

   // Avalon slave with fixed read latency of one; garbage on the bus outside the data cycle.
   initial begin
      avm_waitrequest = 1'b0;
      avm_readdata    = 32'd0;
      forever begin
         @(negedge clk);
         if (pending) begin
            avm_readdata = {31'($urandom), cur_bit};
            pending = 0;
            model_update(cur_bit);
            supply_cnt++;
         end else if (!manual_rd) begin
            avm_readdata = $urandom;
         end
         if (avm_read) begin
            if (!in_read) begin
               in_read    = 1;
               stall_left = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
            end
            if (stall_left > 0) begin
               avm_waitrequest = 1'b1;
               stall_left--;
            end else begin
               avm_waitrequest = 1'b0;
               in_read = 0;
               pending = 1;
               cur_bit = (samp_q.size() > 0) ? samp_q.pop_front() : 1'($urandom_range(0, 1));
            end
         end else begin
            in_read = 0;
            avm_waitrequest = 1'($urandom);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (avm_read && !prev_read) begin
            starts.push_back(cyc);
            run_len = 1;
         end else if (avm_read) begin
            run_len++;
         end
         if (!avm_read && prev_read) last_run = run_len;
         if (avm_read) read_cyc++;
         if (avm_read && (avm_address !== ADDR)) addr_bad++;
         if (flag_rise === 1'b1) rise_seen++;
         if (flag_fall === 1'b1) fall_seen++;
         prev_read = avm_read;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Waits for the next data beat, then two cycles until the debounced result is visible.
   task automatic wait_txn(output bit ok);
      int s0;
      s0 = supply_cnt;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (supply_cnt != s0) begin
            ok = 1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL txn_timeout: no read data within 200 cycles");
      end else begin
         step();
         step();
      end
   endtask

   task automatic poll_one(input bit b, output bit ok);
      samp_q.push_back(b);
      step();
      poll_now = 1'b1;
      step();
      poll_now = 1'b0;
      wait_txn(ok);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      int r0;
      reset = 1'b1; enable = 1'b0; poll_now = 1'b0;
      repeat (3) step();
      total++;
      if ({avm_read, avm_address, flag_level, flag_rise, flag_fall, rise_count} !== 22'd0) begin
         bad++;
         $display("FAIL reset_outputs: got read=%b addr=%0d lvl=%b r=%b f=%b cnt=%0h want all 0",
                  avm_read, avm_address, flag_level, flag_rise, flag_fall, rise_count);
      end
      reset = 1'b0;
      model_reset();
      r0 = starts.size();
      repeat (3 * P) step();
      total++;
      if (starts.size() != r0) begin
         bad++;
         $display("FAIL idle_disabled: got %0d reads want 0", starts.size() - r0);
      end
   endtask

   task automatic test_period();
      int n0, c0, k, rc0;
      stall_cfg = 0;
      n0  = starts.size();
      rc0 = read_cyc;
      c0  = cyc;
      enable = 1'b1;
      repeat (12 * P) step();
      enable = 1'b0;
      repeat (10) step();
      k = starts.size() - n0;
      total++;
      if (k < 11 || k > 12) begin
         bad++;
         $display("FAIL period_count: got %0d polls want 11..12", k);
      end
      if (k > 0) begin
         total++;
         if (starts[n0] - c0 != P) begin
            bad++;
            $display("FAIL first_latency: got %0d want %0d", starts[n0] - c0, P);
         end
      end
      for (int i = n0 + 1; i < starts.size(); i++) begin
         total++;
         if (starts[i] - starts[i-1] != P) begin
            bad++;
            $display("FAIL period_spacing: got %0d want %0d", starts[i] - starts[i-1], P);
         end
      end
      total++;
      if (read_cyc - rc0 != k) begin
         bad++;
         $display("FAIL read_width: got %0d read cycles want %0d", read_cyc - rc0, k);
      end
      total++;
      if (flag_level !== m_level || rise_count !== m_rise_count) begin
         bad++;
         $display("FAIL period_model: got lvl=%b cnt=%0d want lvl=%b cnt=%0d",
                  flag_level, rise_count, m_level, m_rise_count);
      end
   endtask

   task automatic test_waitrequest();
      bit ok;
      stall_cfg = 5;
      for (int i = 0; i < 2; i++) begin
         poll_one(1'b1, ok);
         total++;
         if (last_run != 6) begin
            bad++;
            $display("FAIL stall_read_len: got %0d want 6", last_run);
         end
         total++;
         if (flag_level !== m_level || flag_rise !== m_rise_now || rise_count !== m_rise_count) begin
            bad++;
            $display("FAIL stall_capture: got lvl=%b rise=%b cnt=%0d want lvl=%b rise=%b cnt=%0d",
                     flag_level, flag_rise, rise_count, m_level, m_rise_now, m_rise_count);
         end
      end
      total++;
      if (addr_bad != 0) begin
         bad++;
         $display("FAIL read_address: got %0d bad cycles want 0", addr_bad);
      end
      stall_cfg = 0;
   endtask

   task automatic test_debounce();
      bit ok;
      bit seq[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      int r0, f0;
      pulse_reset();
      stall_cfg = 0;
      r0 = rise_seen;
      f0 = fall_seen;
      for (int i = 0; i < 7; i++) begin
         poll_one(seq[i], ok);
         total++;
         if (flag_level !== m_level || flag_rise !== m_rise_now || flag_fall !== m_fall_now ||
             rise_count !== m_rise_count) begin
            bad++;
            $display("FAIL debounce_step%0d: got lvl=%b r=%b f=%b cnt=%0d want %b %b %b %0d", i,
                     flag_level, flag_rise, flag_fall, rise_count,
                     m_level, m_rise_now, m_fall_now, m_rise_count);
         end
         if (i == 3) begin
            total++;
            if (rise_seen - r0 != 0) begin
               bad++;
               $display("FAIL debounce_early: got %0d rises want 0", rise_seen - r0);
            end
         end
         if (i == 4) begin
            total++;
            if (rise_seen - r0 != 1 || rise_count !== 16'd1 || flag_level !== 1'b1) begin
               bad++;
               $display("FAIL debounce_rise: got rises=%0d cnt=%0d lvl=%b want 1 1 1",
                        rise_seen - r0, rise_count, flag_level);
            end
         end
      end
      total++;
      if (fall_seen - f0 != 1 || flag_level !== 1'b0) begin
         bad++;
         $display("FAIL debounce_fall: got falls=%0d lvl=%b want 1 0", fall_seen - f0, flag_level);
      end
   endtask

   task automatic test_poll_now();
      int r0;
      enable = 1'b0;
      stall_cfg = 3;
      r0 = starts.size();
      step();
      poll_now = 1'b1;
      step();
      poll_now = 1'b0;
      step();
      poll_now = 1'b1;
      step();
      poll_now = 1'b0;
      repeat (3 * P) step();
      total++;
      if (starts.size() - r0 != 1) begin
         bad++;
         $display("FAIL poll_now_once: got %0d reads want 1", starts.size() - r0);
      end
      total++;
      if (flag_level !== m_level || rise_count !== m_rise_count) begin
         bad++;
         $display("FAIL poll_now_model: got lvl=%b cnt=%0d want lvl=%b cnt=%0d",
                  flag_level, rise_count, m_level, m_rise_count);
      end
      stall_cfg = 0;
   endtask

   task automatic test_enable_drop();
      bit ok, seen;
      int r0;
      stall_cfg = 3;
      enable = 1'b1;
      seen = 0;
      for (int i = 0; i < 4 * P; i++) begin
         step();
         if (avm_read) begin
            seen = 1;
            break;
         end
      end
      enable = 1'b0;
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL enable_drop_start: got no read want one within %0d cycles", 4 * P);
      end
      wait_txn(ok);
      total++;
      if (flag_level !== m_level || flag_rise !== m_rise_now || flag_fall !== m_fall_now) begin
         bad++;
         $display("FAIL enable_drop_done: got lvl=%b r=%b f=%b want %b %b %b",
                  flag_level, flag_rise, flag_fall, m_level, m_rise_now, m_fall_now);
      end
      r0 = starts.size();
      repeat (3 * P) step();
      total++;
      if (starts.size() != r0) begin
         bad++;
         $display("FAIL enable_drop_quiet: got %0d reads want 0", starts.size() - r0);
      end
      stall_cfg = 0;
   endtask

   task automatic test_reset_in_req();
      bit ok, seen;
      int r0;
      stall_cfg = 0;
      poll_one(1'b1, ok);
      poll_one(1'b1, ok);
      total++;
      if (flag_level !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset_level: got %b want 1", flag_level);
      end
      stall_cfg = 1000;
      step();
      poll_now = 1'b1;
      step();
      poll_now = 1'b0;
      seen = avm_read;
      step();
      step();
      reset = 1'b1;
      step();
      total++;
      if (!seen || dut.state_q !== StIdle ||
          {avm_read, avm_address, flag_level, flag_rise, flag_fall, rise_count} !== 22'd0) begin
         bad++;
         $display("FAIL reset_in_req: got seen=%b st=%0d read=%b lvl=%b cnt=%0d want 1 0 0 0 0",
                  seen, dut.state_q, avm_read, flag_level, rise_count);
      end
      reset = 1'b0;
      model_reset();
      stall_cfg = 0;
      r0 = starts.size();
      manual_rd = 1;
      avm_readdata = 32'hFFFF_FFFF;
      repeat (6) step();
      manual_rd = 0;
      total++;
      if (flag_level !== 1'b0 || rise_count !== 16'd0 || starts.size() != r0) begin
         bad++;
         $display("FAIL reset_late_data: got lvl=%b cnt=%0d reads=%0d want 0 0 0",
                  flag_level, rise_count, starts.size() - r0);
      end
   endtask

   task automatic test_saturate();
      bit ok;
      bit seq[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int r0;
      pulse_reset();
      force dut.rise_count_q = 16'hFFFE;
      step();
      step();
      release dut.rise_count_q;
      m_rise_count = 16'hFFFE;
      r0 = rise_seen;
      for (int i = 0; i < 10; i++) begin
         poll_one(seq[i], ok);
         total++;
         if (rise_count !== m_rise_count || flag_rise !== m_rise_now) begin
            bad++;
            $display("FAIL saturate_step%0d: got cnt=%0h rise=%b want cnt=%0h rise=%b", i,
                     rise_count, flag_rise, m_rise_count, m_rise_now);
         end
      end
      total++;
      if (rise_count !== 16'hFFFF || rise_seen - r0 != 3) begin
         bad++;
         $display("FAIL saturate_final: got cnt=%0h rises=%0d want ffff 3",
                  rise_count, rise_seen - r0);
      end
   endtask

   task automatic test_random();
      bit ok;
      stall_cfg = -1;
      enable = 1'b1;
      for (int i = 0; i < 40; i++) begin
         wait_txn(ok);
         total++;
         if (flag_level !== m_level || flag_rise !== m_rise_now || flag_fall !== m_fall_now ||
             rise_count !== m_rise_count) begin
            bad++;
            $display("FAIL random_txn%0d: got lvl=%b r=%b f=%b cnt=%0d want %b %b %b %0d", i,
                     flag_level, flag_rise, flag_fall, rise_count,
                     m_level, m_rise_now, m_fall_now, m_rise_count);
         end
      end
      enable = 1'b0;
      stall_cfg = 0;
      repeat (10) step();
   endtask

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      poll_now  = 1'b0;
      manual_rd = 0;
      test_reset();
      test_period();
      test_waitrequest();
      test_debounce();
      test_poll_now();
      test_enable_drop();
      test_reset_in_req();
      test_saturate();
      test_random();
      repeat (5) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
